paddle_array: RTL and testbench
===============================

# paddle_array

Parametrised multi-paddle motion controller for the Pong datapath: the next-generation paddle block. It drives `NUM_PADDLES` independent vertical paddle positions, updated once per video frame. Each channel has a velocity ramp (acceleration under a held button), exact boundary clamping, and an optional AI mode that tracks the ball. It sits between the input debouncers and ball-tracking logic on one side and the renderer and collision logic on the other.

## Interface
Parameters:
- `NUM_PADDLES`, 2, number of independent paddle channels.
- `Y_WIDTH`, 10, width of every vertical coordinate.
- `SCREEN_HEIGHT`, 480, visible lines.
- `PADDLE_HEIGHT`, 60, paddle height in lines.
- `MAX_SPEED`, 8, speed ceiling in lines per frame (≥1).
- `ACCEL_FRAMES`, 4, frames per speed increment under a sustained command (≥1).
- `AI_DEADBAND`, 4, AI tolerance in lines around the ball centre.

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1, reset; asynchronous, active-high. There is one clock domain.
- `frame_tick`, in, 1, one-cycle pulse, once per frame. All state changes happen only on this pulse.
- `move_up`, in, NUM_PADDLES, manual up request; bit i belongs to channel i.
- `move_down`, in, NUM_PADDLES, manual down request.
- `ai_mode`, in, NUM_PADDLES, 1 = channel i is driven by the AI tracker and its manual inputs are ignored.
- `ball_y`, in, Y_WIDTH, ball centre line used by the AI tracker.
- `paddle_y`, out, NUM_PADDLES*Y_WIDTH, top line of each paddle. Channel i is in bits [i*Y_WIDTH +: Y_WIDTH].
- `moving`, out, NUM_PADDLES, 1 while channel i is in state UP or DOWN.

## Operation
- Let YMAX = SCREEN_HEIGHT − PADDLE_HEIGHT (420 with defaults).
- Reset values, per channel: `paddle_y` = YMAX/2 (210), speed = 0, accel count = 0, state IDLE, `moving` = 0.
- Command per channel, sampled on `frame_tick`:
  - Manual mode: up = `move_up & ~move_down`; down = `move_down & ~move_up`. Both asserted, or neither, gives none.
  - AI mode: the centre is `paddle_y` + PADDLE_HEIGHT/2. The command is up if centre > `ball_y` + AI_DEADBAND, down if centre + AI_DEADBAND < `ball_y`, otherwise none.
- State machine per channel: states IDLE, UP, DOWN. On each tick:
  - Command none → IDLE; speed = 0; count = 0; no motion.
  - Command matches the current state → speed and count advance:
    - If count == ACCEL_FRAMES−1: s' = min(speed+1, MAX_SPEED) and count = 0.
    - Otherwise: s' = speed and count + 1.
  - Command differs from the current non-matching state (including a reversal) → enter the commanded state; s' = 1; count = 0.
  - A change in `ai_mode[i]` since the previous tick forces a re-entry: s' = 1 if a direction is commanded, otherwise IDLE.
- Motion uses s' on the same tick:
  - Up: y' = (y ≥ s') ? y − s' : 0.
  - Down: y' = min(y + s', YMAX).
  - Arithmetic is Y_WIDTH+1 bits wide, so there is no wrap-around.
- Clamping never changes the state or the speed. A paddle pinned at a bound with its command held stays in UP or DOWN with `moving` = 1.
- Channels are fully independent. A shared `ball_y` does not couple them.

## Timing
- Inputs are sampled only in the cycle where `frame_tick` = 1. Between ticks they are ignored.
- `paddle_y` and `moving` are registered and change in the cycle after the tick; the latency is 1 clock.
- Consecutive-cycle ticks are legal. Each tick is processed independently.
- If `rst` is asserted mid-frame or coincides with a tick, reset wins immediately and asynchronously. The first tick after release applies from the reset state.

## Structure
- Package `pong_pkg`:
  - Constants: SCREEN_HEIGHT, PADDLE_HEIGHT, MAX_SPEED defaults.
  - Direction enum `dir_t` {IDLE, UP, DOWN}.
- Sub-module `paddle_channel`:
  - Contains one channel's FSM, speed/count registers, AI comparator and clamp.
  - `paddle_array` instantiates it NUM_PADDLES times in a generate loop and concatenates the outputs.

## Test plan
All scenarios use the default parameters.
- Reset → `paddle_y` = {210,210} and `moving` = 0. Assert `rst` mid-frame with y=300 → y returns to 210 without waiting for a clock edge.
- Hold `move_up[0]` for 5 ticks from 210 → y = 209, 208, 207, 206, then 204 (speed becomes 2 on tick 5). Channel 1 stays at 210.
- Hold `move_down[1]` from y=418 with the speed ramped to 4 → y = 420 (clamped). Subsequent ticks keep y = 420 and `moving` = 1. Release → IDLE, `moving` = 0.
- Assert `move_up` and `move_down` together, then reverse direction while at speed 3 → no motion and IDLE for the simultaneous case; the reversal restarts at speed 1 (y changes by 1).
- Set `ai_mode[0]`=1, `ball_y`=100, y=210 (centre 240) → up commands ramp y down until centre ≤ 104, then IDLE. Set `ball_y`=242 (within the deadband of centre 240) → no motion.
- Toggle `frame_tick` off with inputs held → outputs remain constant. Issue back-to-back ticks in consecutive cycles → two updates, one per tick, each visible 1 cycle later.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_pkg : shared constants and the paddle direction type
// Rev 1.0
// ---------------------------------------------------------------------------
package pong_pkg;

   localparam int c_SCREEN_HEIGHT = 480;
   localparam int c_PADDLE_HEIGHT = 60;
   localparam int c_MAX_SPEED     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } dir_t;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/paddle_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// paddle_channel : one paddle's direction FSM, speed ramp, AI tracker, clamp
// Rev 1.0
// ---------------------------------------------------------------------------
module paddle_channel
   import pong_pkg::*;
#(
   parameter int Y_WIDTH       = 10,
   parameter int SCREEN_HEIGHT = c_SCREEN_HEIGHT,
   parameter int PADDLE_HEIGHT = c_PADDLE_HEIGHT,
   parameter int MAX_SPEED     = c_MAX_SPEED,
   parameter int ACCEL_FRAMES  = 4,
   parameter int AI_DEADBAND   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               move_up,
   input  logic               move_down,
   input  logic               ai_mode,
   input  logic [Y_WIDTH-1:0] ball_y,
   output logic [Y_WIDTH-1:0] paddle_y,
   output logic               moving
);

   localparam int YMAX  = SCREEN_HEIGHT - PADDLE_HEIGHT;
   localparam int SPD_W = $clog2(MAX_SPEED + 1);
   localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

   localparam logic [Y_WIDTH:0]   c_YMAX     = (Y_WIDTH+1)'(YMAX);
   localparam logic [Y_WIDTH-1:0] c_YRST     = Y_WIDTH'(YMAX / 2);
   localparam logic [Y_WIDTH:0]   c_HALF_H   = (Y_WIDTH+1)'(PADDLE_HEIGHT / 2);
   localparam logic [Y_WIDTH:0]   c_DEADBAND = (Y_WIDTH+1)'(AI_DEADBAND);
   localparam logic [SPD_W-1:0]   c_MAX_SPD  = SPD_W'(MAX_SPEED);
   localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);

   logic [Y_WIDTH-1:0] r_y;
   logic [SPD_W-1:0]   r_speed;
   logic [CNT_W-1:0]   r_count;
   dir_t               r_state;
   logic               r_ai_prev;

   dir_t               w_cmd;
   dir_t               w_state_nxt;
   logic [SPD_W-1:0]   w_speed_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [Y_WIDTH-1:0] w_y_nxt;
   logic [Y_WIDTH:0]   w_centre;
   logic [Y_WIDTH:0]   w_ball;
   logic [Y_WIDTH:0]   w_step;
   logic [Y_WIDTH:0]   w_sum;
   logic [Y_WIDTH:0]   w_y_wide;

   // One extra bit on all coordinate arithmetic so sums and compares never wrap
   assign w_centre = {1'b0, r_y} + c_HALF_H;
   assign w_ball   = {1'b0, ball_y};

   always_comb begin
      w_cmd = IDLE;
      if (ai_mode) begin
         if (w_centre > (w_ball + c_DEADBAND))
            w_cmd = UP;
         else if ((w_centre + c_DEADBAND) < w_ball)
            w_cmd = DOWN;
      end else begin
         if (move_up && !move_down)
            w_cmd = UP;
         else if (move_down && !move_up)
            w_cmd = DOWN;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_speed_nxt = r_speed;
      w_count_nxt = r_count;
      if (w_cmd == IDLE) begin
         w_state_nxt = IDLE;
         w_speed_nxt = '0;
         w_count_nxt = '0;
      end else if ((ai_mode != r_ai_prev) || (w_cmd != r_state)) begin
         w_state_nxt = w_cmd;
         w_speed_nxt = SPD_W'(1);
         w_count_nxt = '0;
      end else if (r_count == c_CNT_LAST) begin
         w_speed_nxt = (r_speed == c_MAX_SPD) ? c_MAX_SPD : r_speed + SPD_W'(1);
         w_count_nxt = '0;
      end else begin
         w_count_nxt = r_count + CNT_W'(1);
      end
   end

   // Motion uses the freshly computed speed; clamping leaves state and speed alone
   always_comb begin
      w_step   = (Y_WIDTH+1)'(w_speed_nxt);
      w_sum    = {1'b0, r_y} + w_step;
      w_y_wide = {1'b0, r_y};
      case (w_state_nxt)
         UP:      w_y_wide = ({1'b0, r_y} >= w_step) ? ({1'b0, r_y} - w_step) : '0;
         DOWN:    w_y_wide = (w_sum > c_YMAX) ? c_YMAX : w_sum;
         default: w_y_wide = {1'b0, r_y};
      endcase
      w_y_nxt = Y_WIDTH'(w_y_wide);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y       <= c_YRST;
         r_speed   <= '0;
         r_count   <= '0;
         r_state   <= IDLE;
         r_ai_prev <= 1'b0;
      end else if (frame_tick) begin
         r_y       <= w_y_nxt;
         r_speed   <= w_speed_nxt;
         r_count   <= w_count_nxt;
         r_state   <= w_state_nxt;
         r_ai_prev <= ai_mode;
      end
   end

   assign paddle_y = r_y;
   assign moving   = (r_state != IDLE);

endmodule : paddle_channel
`default_nettype wire

// File: rtl/paddle_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// paddle_array : NUM_PADDLES independent paddle channels updated per frame
// Rev 1.0
// ---------------------------------------------------------------------------
module paddle_array
   import pong_pkg::*;
#(
   parameter int NUM_PADDLES   = 2,
   parameter int Y_WIDTH       = 10,
   parameter int SCREEN_HEIGHT = c_SCREEN_HEIGHT,
   parameter int PADDLE_HEIGHT = c_PADDLE_HEIGHT,
   parameter int MAX_SPEED     = c_MAX_SPEED,
   parameter int ACCEL_FRAMES  = 4,
   parameter int AI_DEADBAND   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           frame_tick,
   input  logic [NUM_PADDLES-1:0]         move_up,
   input  logic [NUM_PADDLES-1:0]         move_down,
   input  logic [NUM_PADDLES-1:0]         ai_mode,
   input  logic [Y_WIDTH-1:0]             ball_y,
   output logic [NUM_PADDLES*Y_WIDTH-1:0] paddle_y,
   output logic [NUM_PADDLES-1:0]         moving
);

   for (genvar gi = 0; gi < NUM_PADDLES; gi++) begin : g_ch
      paddle_channel #(
         .Y_WIDTH       (Y_WIDTH),
         .SCREEN_HEIGHT (SCREEN_HEIGHT),
         .PADDLE_HEIGHT (PADDLE_HEIGHT),
         .MAX_SPEED     (MAX_SPEED),
         .ACCEL_FRAMES  (ACCEL_FRAMES),
         .AI_DEADBAND   (AI_DEADBAND)
      ) u_channel (
         .clk        (clk),
         .rst        (rst),
         .frame_tick (frame_tick),
         .move_up    (move_up[gi]),
         .move_down  (move_down[gi]),
         .ai_mode    (ai_mode[gi]),
         .ball_y     (ball_y),
         .paddle_y   (paddle_y[gi*Y_WIDTH +: Y_WIDTH]),
         .moving     (moving[gi])
      );
   end

endmodule : paddle_array
`default_nettype wire

// File: tb/tb_paddle_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_paddle_array : directed self-checking bench for paddle_array (defaults)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_paddle_array;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic [1:0]  move_up = '0;
   logic [1:0]  move_down = '0;
   logic [1:0]  ai_mode = '0;
   logic [9:0]  ball_y = '0;
   logic [19:0] paddle_y;
   logic [1:0]  moving;

   int n_tests = 0;
   int n_fail  = 0;

   paddle_array dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .move_up    (move_up),
      .move_down  (move_down),
      .ai_mode    (ai_mode),
      .ball_y     (ball_y),
      .paddle_y   (paddle_y),
      .moving     (moving)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] y0();
      return paddle_y[9:0];
   endfunction

   function automatic logic [9:0] y1();
      return paddle_y[19:10];
   endfunction

   // Each tick is high across exactly one rising edge; returns at the following falling edge
   task automatic tick_n(input int n);
      repeat (n) begin
         @(negedge clk) frame_tick = 1'b1;
         @(negedge clk) frame_tick = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      move_up = '0; move_down = '0; ai_mode = '0; ball_y = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_tests++;
      if (paddle_y !== {10'd210, 10'd210}) begin
         n_fail++; $display("FAIL reset_y: got %h want %h", paddle_y, {10'd210, 10'd210});
      end
      n_tests++;
      if (moving !== 2'b00) begin
         n_fail++; $display("FAIL reset_moving: got %b want 00", moving);
      end
      rst = 1'b0;
   endtask

   task automatic test_async_reset();
      move_down = 2'b01;
      tick_n(25);
      n_tests++;
      if (y0() !== 10'd301) begin
         n_fail++; $display("FAIL pre_reset_y0: got %0d want 301", y0());
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (y0() !== 10'd210 || moving !== 2'b00) begin
         n_fail++; $display("FAIL async_reset: got y0=%0d mv=%b want 210/00", y0(), moving);
      end
      move_down = '0;
      #1 rst = 1'b0;
   endtask

   task automatic test_ramp_up();
      logic [9:0] exp_y [5];
      exp_y = '{10'd209, 10'd208, 10'd207, 10'd206, 10'd204};
      do_reset();
      move_up = 2'b01;
      for (int i = 0; i < 5; i++) begin
         tick_n(1);
         n_tests++;
         if (y0() !== exp_y[i] || y1() !== 10'd210 || moving !== 2'b01) begin
            n_fail++;
            $display("FAIL ramp_tick%0d: got y0=%0d y1=%0d mv=%b want %0d/210/01",
                     i + 1, y0(), y1(), moving, exp_y[i]);
         end
      end
   endtask

   task automatic test_clamp();
      do_reset();
      move_up = 2'b01; move_down = 2'b10;
      tick_n(40);
      n_tests++;
      if (y0() !== 10'd2 || y1() !== 10'd418) begin
         n_fail++; $display("FAIL clamp_approach: got y0=%0d y1=%0d want 2/418", y0(), y1());
      end
      for (int i = 0; i < 3; i++) begin
         tick_n(1);
         n_tests++;
         if (y0() !== 10'd0 || y1() !== 10'd420 || moving !== 2'b11) begin
            n_fail++;
            $display("FAIL clamp_hold%0d: got y0=%0d y1=%0d mv=%b want 0/420/11",
                     i, y0(), y1(), moving);
         end
      end
      move_up = '0; move_down = '0;
      tick_n(1);
      n_tests++;
      if (y0() !== 10'd0 || y1() !== 10'd420 || moving !== 2'b00) begin
         n_fail++; $display("FAIL clamp_release: got y0=%0d y1=%0d mv=%b want 0/420/00", y0(), y1(), moving);
      end
   endtask

   task automatic test_both_reverse();
      do_reset();
      move_up = 2'b01; move_down = 2'b01;
      tick_n(1);
      n_tests++;
      if (y0() !== 10'd210 || moving !== 2'b00) begin
         n_fail++; $display("FAIL both_pressed: got y0=%0d mv=%b want 210/00", y0(), moving);
      end
      move_down = 2'b00;
      tick_n(9);
      n_tests++;
      if (y0() !== 10'd195) begin
         n_fail++; $display("FAIL up_speed3: got y0=%0d want 195", y0());
      end
      move_up = 2'b00; move_down = 2'b01;
      tick_n(1);
      n_tests++;
      if (y0() !== 10'd196 || moving !== 2'b01) begin
         n_fail++; $display("FAIL reversal: got y0=%0d mv=%b want 196/01", y0(), moving);
      end
   endtask

   task automatic test_ai();
      do_reset();
      ai_mode = 2'b01; ball_y = 10'd100; move_down = 2'b01;
      tick_n(31);
      n_tests++;
      if (y0() !== 10'd74 || moving !== 2'b01 || y1() !== 10'd210) begin
         n_fail++; $display("FAIL ai_track: got y0=%0d y1=%0d mv=%b want 74/210/01", y0(), y1(), moving);
      end
      tick_n(1);
      n_tests++;
      if (y0() !== 10'd74 || moving !== 2'b00) begin
         n_fail++; $display("FAIL ai_settle: got y0=%0d mv=%b want 74/00", y0(), moving);
      end
      do_reset();
      ai_mode = 2'b01; ball_y = 10'd242;
      tick_n(3);
      n_tests++;
      if (y0() !== 10'd210 || moving !== 2'b00) begin
         n_fail++; $display("FAIL ai_deadband: got y0=%0d mv=%b want 210/00", y0(), moving);
      end
   endtask

   task automatic test_no_tick();
      do_reset();
      move_up = 2'b01;
      tick_n(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if (y0() !== 10'd209 || moving !== 2'b01) begin
            n_fail++; $display("FAIL no_tick%0d: got y0=%0d mv=%b want 209/01", i, y0(), moving);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk);
      n_tests++;
      if (y0() !== 10'd208) begin
         n_fail++; $display("FAIL b2b_first: got y0=%0d want 208", y0());
      end
      @(negedge clk) frame_tick = 1'b0;
      n_tests++;
      if (y0() !== 10'd207) begin
         n_fail++; $display("FAIL b2b_second: got y0=%0d want 207", y0());
      end
      @(negedge clk);
      n_tests++;
      if (y0() !== 10'd207) begin
         n_fail++; $display("FAIL b2b_after: got y0=%0d want 207", y0());
      end
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_ramp_up();
      test_clamp();
      test_both_reverse();
      test_ai();
      test_no_tick();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule : tb_paddle_array
`default_nettype wire
